gshare_bp: RTL and testbench
============================

Name: gshare_bp

Overview:
Parametrised gshare branch predictor, the next generation of the fetch-stage 2-bit global-history BHT. It generalises table depth, history length and counter width. It adds a speculative global history register (GHR) with mispredict repair, a split predict/update interface, and a registered prediction response. It also adds a sequential table-initialisation sweep and a saturating mispredict statistic. It sits between fetch (predict port) and branch resolution in execute (update port).

Parameters:
INDEX_W, 6, log2 of table entries (64 entries default)
HIST_W, 6, global history length in bits; legal range 1..INDEX_W
CTR_W, 2, saturating counter width; legal range 2..4
TAG_WIDTH, 6, width of hashed PC tag; truncated or zero-extended to INDEX_W
STAT_W, 16, mispredict statistic counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
pred_valid  in  1  fetch requests a prediction this cycle
pred_tag  in  TAG_WIDTH  hashed PC of predicted branch
pred_ready  out  1  high when predictions are accepted (low during init)
pred_resp_valid  out  1  registered: prediction result valid
pred_taken  out  1  registered: predicted direction
pred_hist  out  HIST_W  registered: speculative GHR used to form the index; carried down the pipeline
upd_valid  in  1  branch resolved this cycle
upd_tag  in  TAG_WIDTH  hashed PC of resolved branch
upd_hist  in  HIST_W  pred_hist returned with the resolved branch
upd_taken  in  1  actual direction
upd_mispredict  in  1  resolved direction differed from prediction
init_busy  out  1  table sweep in progress
stat_mispredicts  out  STAT_W  count of mispredicting updates, saturating

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-low. All state clears on rst low, independent of clk.
- Reset values: spec_ghr=0, sweep pointer=0, FSM=INIT, init_busy=1, pred_ready=0, pred_resp_valid=0, pred_taken=0, pred_hist=0, stat_mispredicts=0. The table is not reset directly.
- FSM INIT: writes CTR_INIT = 2^(CTR_W-1) (weakly taken) to entry[ptr] each cycle and increments ptr. After writing entry 2^INDEX_W-1, moves to READY on the next edge. INIT lasts exactly 2^INDEX_W cycles.
- In INIT, pred_valid and upd_valid are ignored, with no state change.
- FSM READY: init_busy=0, pred_ready=1. Stays in READY until reset.
- Index: idx = zero-extend(hist, INDEX_W) XOR resize(tag, INDEX_W).
- Predict: on an edge with pred_valid & pred_ready:
  - idx uses spec_ghr and pred_tag.
  - pred_taken <= MSB of counter[idx].
  - pred_hist <= current spec_ghr.
  - pred_resp_valid <= 1, i.e. one-cycle latency.
  - spec_ghr <= {spec_ghr[HIST_W-2:0], predicted bit}; for HIST_W=1 it is replaced by the predicted bit.
  - pred_resp_valid <= 0 on any edge without an accepted request. pred_taken and pred_hist hold their values.
- Update: on an edge with upd_valid in READY:
  - idx uses upd_hist and upd_tag.
  - Counter increments if upd_taken, else decrements.
  - Counter saturates at 2^CTR_W-1 and 0; no wrap.
  - Write takes effect at that edge.
- Repair: upd_valid & upd_mispredict sets spec_ghr <= {upd_hist[HIST_W-2:0], upd_taken}.
  - Repair overrides the shift from a same-cycle prediction.
  - That prediction's response is still issued, with the pre-repair pred_hist (wrong-path; fetch flushes it).
  - A non-mispredict update never touches spec_ghr.
- Same-cycle predict and update to the same idx: the read returns the pre-update value (read-before-write).
- stat_mispredicts increments on each upd_valid & upd_mispredict in READY. It holds at all-ones.
- upd_mispredict without upd_valid is ignored.
- Reset mid-INIT or mid-READY: everything returns to reset values and the sweep restarts from 0. Any in-flight pred_resp_valid drops immediately.

Test Plan:
- Reset release, defaults -> init_busy=1 and pred_ready=0 for exactly 64 cycles, then pred_ready=1. First prediction on any tag gives pred_taken=1 (counter 2), pred_hist=0.
- Tag 0x05, 4 updates taken then 5 not-taken with upd_hist=0 -> counter reaches 3 (no wrap past 3) then 0. Prediction with spec_ghr=0 on tag 0x05 returns pred_taken=0.
- Three back-to-back predictions -> pred_hist sequence 0b000000, 0b000001, 0b000011 (all weakly taken). pred_resp_valid high each cycle after request, low after requests stop.
- Mispredict with upd_hist=0b000101, upd_taken=0, concurrent with a predict -> spec_ghr becomes 0b001010, not shifted. The concurrent response carries the old history.
- Same-cycle predict and update to the same idx (counter 2, update not-taken) -> pred_taken=1; the next predict to that idx gives 0.
- STAT_W=2: five mispredicts -> stat_mispredicts 1,2,3,3,3. Reset pulse mid-INIT at cycle 20 -> sweep restarts and needs a full 64 cycles again.

Source files
------------

// File: rtl/gshare_bp.sv
// gshare_bp: gshare branch direction predictor for the fetch/execute pipeline.
//
// A table of 2^INDEX_W saturating counters is indexed by the XOR of a global
// branch history and a hashed PC tag. Fetch asks for predictions on the predict
// port and gets a registered answer one cycle later. Execute reports resolved
// branches on the update port, which trains the counters and, on a mispredict,
// repairs the speculative global history register (GHR).
//
// After reset the table is swept to weakly-taken, one entry per cycle. No
// requests are accepted while the sweep runs.
//
// Ports:
//   clk              clock
//   rst              asynchronous, active-low reset
//   pred_valid       fetch requests a prediction this cycle
//   pred_tag         hashed PC of the branch being predicted
//   pred_ready       predictions accepted (low while the table sweep runs)
//   pred_resp_valid  registered: a prediction response is valid
//   pred_taken       registered: predicted direction
//   pred_hist        registered: speculative history used for that prediction
//   upd_valid        a branch resolved this cycle
//   upd_tag          hashed PC of the resolved branch
//   upd_hist         pred_hist that travelled down with the resolved branch
//   upd_taken        actual branch direction
//   upd_mispredict   the resolved direction differed from the prediction
//   init_busy        table sweep in progress
//   stat_mispredicts saturating count of mispredicting updates
module gshare_bp #(
    parameter int INDEX_W   = 6,
    parameter int HIST_W    = 6,
    parameter int CTR_W     = 2,
    parameter int TAG_WIDTH = 6,
    parameter int STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic [TAG_WIDTH-1:0] pred_tag,
    output logic                 pred_ready,
    output logic                 pred_resp_valid,
    output logic                 pred_taken,
    output logic [HIST_W-1:0]    pred_hist,
    input  logic                 upd_valid,
    input  logic [TAG_WIDTH-1:0] upd_tag,
    input  logic [HIST_W-1:0]    upd_hist,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic                 init_busy,
    output logic [STAT_W-1:0]    stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_USE = (TAG_WIDTH < INDEX_W) ? TAG_WIDTH : INDEX_W;
    localparam logic [CTR_W-1:0]   CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0]   CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [INDEX_W-1:0] PTR_LAST = {INDEX_W{1'b1}};

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [INDEX_W-1:0]   ptr;
    logic [HIST_W-1:0]    spec_ghr;
    logic [CTR_W-1:0]     ctr_table [ENTRIES];

    logic                 pred_fire;
    logic                 upd_fire;
    logic                 repair;
    logic [INDEX_W-1:0]   pred_idx;
    logic [INDEX_W-1:0]   upd_idx;
    logic [CTR_W-1:0]     pred_ctr;
    logic                 pred_bit;
    logic [CTR_W-1:0]     upd_ctr_next;

    // History is zero-extended and the tag truncated or zero-extended, both
    // to INDEX_W, before the XOR.
    function automatic logic [INDEX_W-1:0] make_idx(
        input logic [HIST_W-1:0]    hist,
        input logic [TAG_WIDTH-1:0] tag
    );
        logic [INDEX_W-1:0] h_ext;
        logic [INDEX_W-1:0] t_ext;
        h_ext = '0;
        t_ext = '0;
        for (int i = 0; i < HIST_W; i++) h_ext[i] = hist[i];
        for (int i = 0; i < TAG_USE; i++) t_ext[i] = tag[i];
        return h_ext ^ t_ext;
    endfunction

    // Shift a direction bit into the young end of a history. Written as a
    // loop so that HIST_W=1 simply replaces the single bit.
    function automatic logic [HIST_W-1:0] shift_in(
        input logic [HIST_W-1:0] hist,
        input logic              dir
    );
        logic [HIST_W-1:0] r;
        r[0] = dir;
        for (int i = 1; i < HIST_W; i++) r[i] = hist[i-1];
        return r;
    endfunction

    function automatic logic [CTR_W-1:0] sat_step(
        input logic [CTR_W-1:0] c,
        input logic             up
    );
        if (up) begin
            return (c == CTR_MAX) ? c : c + 1'b1;
        end
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] s);
        return (s == {STAT_W{1'b1}}) ? s : s + 1'b1;
    endfunction

    assign init_busy  = (state == ST_INIT);
    assign pred_ready = (state == ST_READY);

    assign pred_fire = pred_valid & pred_ready;
    assign upd_fire  = upd_valid & pred_ready;
    assign repair    = upd_fire & upd_mispredict;

    assign pred_idx     = make_idx(spec_ghr, pred_tag);
    assign upd_idx      = make_idx(upd_hist, upd_tag);
    // The read happens before this edge's update write lands, so a
    // same-cycle predict/update on one entry sees the old counter.
    assign pred_ctr     = ctr_table[pred_idx];
    assign pred_bit     = pred_ctr[CTR_W-1];
    assign upd_ctr_next = sat_step(ctr_table[upd_idx], upd_taken);

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (ptr == PTR_LAST) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) ptr <= ptr + 1'b1;
        end
    end

    // Counter table: no reset, initialised by the sweep.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            ctr_table[ptr] <= CTR_INIT;
        end else if (upd_fire) begin
            ctr_table[upd_idx] <= upd_ctr_next;
        end
    end

    // Prediction response stage and speculative history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_ghr        <= '0;
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
            pred_hist       <= '0;
        end else begin
            pred_resp_valid <= pred_fire;
            if (pred_fire) begin
                pred_taken <= pred_bit;
                pred_hist  <= spec_ghr;
            end
            // Repair wins over a same-cycle speculative shift; the response
            // issued alongside it is wrong-path and fetch discards it.
            if (repair) begin
                spec_ghr <= shift_in(upd_hist, upd_taken);
            end else if (pred_fire) begin
                spec_ghr <= shift_in(spec_ghr, pred_bit);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_mispredicts <= '0;
        end else if (repair) begin
            stat_mispredicts <= sat_inc(stat_mispredicts);
        end
    end

endmodule

// File: tb/tb_gshare_bp.sv
module tb_gshare_bp;

    localparam int INDEX_W   = 6;
    localparam int HIST_W    = 6;
    localparam int CTR_W     = 2;
    localparam int TAG_WIDTH = 6;
    localparam int STAT_W    = 2;

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int IMASK   = ENTRIES - 1;
    localparam int HMASK   = (1 << HIST_W) - 1;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int CINIT   = 1 << (CTR_W - 1);
    localparam int SMAX    = (1 << STAT_W) - 1;

    logic                 clk;
    logic                 rst;
    logic                 pred_valid;
    logic [TAG_WIDTH-1:0] pred_tag;
    logic                 pred_ready;
    logic                 pred_resp_valid;
    logic                 pred_taken;
    logic [HIST_W-1:0]    pred_hist;
    logic                 upd_valid;
    logic [TAG_WIDTH-1:0] upd_tag;
    logic [HIST_W-1:0]    upd_hist;
    logic                 upd_taken;
    logic                 upd_mispredict;
    logic                 init_busy;
    logic [STAT_W-1:0]    stat_mispredicts;

    gshare_bp #(
        .INDEX_W  (INDEX_W),
        .HIST_W   (HIST_W),
        .CTR_W    (CTR_W),
        .TAG_WIDTH(TAG_WIDTH),
        .STAT_W   (STAT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_valid      (pred_valid),
        .pred_tag        (pred_tag),
        .pred_ready      (pred_ready),
        .pred_resp_valid (pred_resp_valid),
        .pred_taken      (pred_taken),
        .pred_hist       (pred_hist),
        .upd_valid       (upd_valid),
        .upd_tag         (upd_tag),
        .upd_hist        (upd_hist),
        .upd_taken       (upd_taken),
        .upd_mispredict  (upd_mispredict),
        .init_busy       (init_busy),
        .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: plain integers describing the predictor's rules.
    int m_ctr [ENTRIES];
    int m_ghr;
    int m_stat;
    int m_init_left;
    int m_valid;
    int m_taken;
    int m_hist;

    typedef struct {
        bit   pv;
        int   ptag;
        bit   uv;
        int   utag;
        int   uhist;
        bit   ut;
        bit   um;
        int   ev;
        int   et;
        int   eh;
        int   es;
    } vec_t;

    vec_t vt [23];

    function automatic vec_t mk(bit pv, int ptag, bit uv, int utag, int uhist,
                                bit ut, bit um, int ev, int et, int eh, int es);
        vec_t v;
        v.pv = pv; v.ptag = ptag; v.uv = uv; v.utag = utag; v.uhist = uhist;
        v.ut = ut; v.um = um; v.ev = ev; v.et = et; v.eh = eh; v.es = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ghr = 0;
        m_stat = 0;
        m_init_left = ENTRIES;
        m_valid = 0;
        m_taken = 0;
        m_hist = 0;
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CINIT;
    endtask

    task automatic model_edge();
        int pidx;
        int uidx;
        int new_ghr;
        int t;
        if (m_init_left > 0) begin
            m_init_left--;
            m_valid = 0;
            return;
        end
        pidx = (m_ghr ^ int'(pred_tag)) & IMASK;
        uidx = (int'(upd_hist) ^ int'(upd_tag)) & IMASK;
        new_ghr = m_ghr;
        if (pred_valid) begin
            t = (m_ctr[pidx] >= CINIT) ? 1 : 0;
            m_taken = t;
            m_hist = m_ghr;
            m_valid = 1;
            new_ghr = ((m_ghr << 1) | t) & HMASK;
        end else begin
            m_valid = 0;
        end
        if (upd_valid) begin
            if (upd_taken) m_ctr[uidx] = (m_ctr[uidx] < CMAX) ? m_ctr[uidx] + 1 : CMAX;
            else           m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
            if (upd_mispredict) begin
                new_ghr = ((int'(upd_hist) << 1) | int'(upd_taken)) & HMASK;
                m_stat = (m_stat < SMAX) ? m_stat + 1 : SMAX;
            end
        end
        m_ghr = new_ghr;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".resp_valid"}, pred_resp_valid, m_valid);
        chk({tag, ".taken"},      pred_taken,      m_taken);
        chk({tag, ".hist"},       pred_hist,       m_hist);
        chk({tag, ".ready"},      pred_ready,      (m_init_left == 0) ? 1 : 0);
        chk({tag, ".busy"},       init_busy,       (m_init_left != 0) ? 1 : 0);
        chk({tag, ".stat"},       stat_mispredicts, m_stat);
    endtask

    task automatic drive(input bit pv, input int ptag, input bit uv, input int utag,
                         input int uhist, input bit ut, input bit um);
        pred_valid     = pv;
        pred_tag       = TAG_WIDTH'(ptag);
        upd_valid      = uv;
        upd_tag        = TAG_WIDTH'(utag);
        upd_hist       = HIST_W'(uhist);
        upd_taken      = ut;
        upd_mispredict = um;
    endtask

    // One clock: inputs already driven, model follows the edge, outputs
    // sampled 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic idle_cycle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle(tag);
    endtask

    // Assert reset between clock edges, check the asynchronous clear, then
    // release it just after an edge.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_model("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_model("reset_release");
    endtask

    task automatic wait_ready(input string tag, input int expect_cycles);
        int n;
        n = 0;
        while (!pred_ready && n < 200) begin
            idle_cycle(tag);
            n++;
        end
        chk({tag, ".init_cycles"}, n, expect_cycles);
    endtask

    initial begin
        int sexp [5];
        int hpick;
        vectors = 0;
        miscompares = 0;

        vt[0]  = mk(1, 'h11, 0, 0,    0,    0, 0,  1, 1, 'h00, 0);
        vt[1]  = mk(0, 0,    1, 'h05, 0,    1, 0,  0, 1, 'h00, 0);
        vt[2]  = mk(0, 0,    1, 'h05, 0,    1, 0,  0, 1, 'h00, 0);
        vt[3]  = mk(0, 0,    1, 'h05, 0,    1, 0,  0, 1, 'h00, 0);
        vt[4]  = mk(0, 0,    1, 'h05, 0,    1, 0,  0, 1, 'h00, 0);
        vt[5]  = mk(0, 0,    1, 'h05, 0,    0, 0,  0, 1, 'h00, 0);
        vt[6]  = mk(0, 0,    1, 'h05, 0,    0, 0,  0, 1, 'h00, 0);
        vt[7]  = mk(0, 0,    1, 'h05, 0,    0, 0,  0, 1, 'h00, 0);
        vt[8]  = mk(0, 0,    1, 'h05, 0,    0, 0,  0, 1, 'h00, 0);
        vt[9]  = mk(0, 0,    1, 'h05, 0,    0, 0,  0, 1, 'h00, 0);
        vt[10] = mk(0, 0,    1, 'h3F, 0,    0, 1,  0, 1, 'h00, 1);
        vt[11] = mk(1, 'h05, 0, 0,    0,    0, 0,  1, 0, 'h00, 1);
        vt[12] = mk(1, 'h20, 0, 0,    0,    0, 0,  1, 1, 'h00, 1);
        vt[13] = mk(1, 'h20, 0, 0,    0,    0, 0,  1, 1, 'h01, 1);
        vt[14] = mk(1, 'h20, 0, 0,    0,    0, 0,  1, 1, 'h03, 1);
        vt[15] = mk(0, 0,    0, 0,    0,    0, 0,  0, 1, 'h03, 1);
        vt[16] = mk(1, 'h20, 1, 'h10, 'h05, 0, 1,  1, 1, 'h07, 2);
        vt[17] = mk(1, 'h20, 0, 0,    0,    0, 0,  1, 1, 'h0A, 2);
        vt[18] = mk(1, 'h08, 1, 'h1D, 0,    0, 0,  1, 1, 'h15, 2);
        vt[19] = mk(1, 'h36, 0, 0,    0,    0, 0,  1, 0, 'h2B, 2);
        vt[20] = mk(0, 0,    1, 'h3F, 'h3F, 1, 1,  0, 0, 'h2B, 3);
        vt[21] = mk(0, 0,    1, 'h01, 0,    1, 1,  0, 0, 'h2B, 3);
        vt[22] = mk(1, 'h00, 0, 0,    0,    0, 0,  1, 1, 'h01, 3);

        sexp[0] = 1; sexp[1] = 2; sexp[2] = 3; sexp[3] = 3; sexp[4] = 3;

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_model("power_on");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Requests held during the sweep are ignored; reset at cycle 20
        // restarts it.
        for (int i = 0; i < 20; i++) begin
            drive(1, i, 1, i, i, 1, 1);
            cycle("init_ignore");
        end
        do_reset();
        wait_ready("restart", ENTRIES);

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].pv, vt[i].ptag, vt[i].uv, vt[i].utag, vt[i].uhist, vt[i].ut, vt[i].um);
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.valid", i), pred_resp_valid,  vt[i].ev);
            chk($sformatf("vec%0d.taken", i), pred_taken,       vt[i].et);
            chk($sformatf("vec%0d.hist", i),  pred_hist,        vt[i].eh);
            chk($sformatf("vec%0d.stat", i),  stat_mispredicts, vt[i].es);
        end

        // A live response is cleared immediately by reset.
        drive(1, 3, 0, 0, 0, 0, 0);
        cycle("pre_reset_pred");
        chk("pre_reset_valid", pred_resp_valid, 1);
        do_reset();
        chk("reset_drops_valid", pred_resp_valid, 0);
        wait_ready("reinit", ENTRIES);

        // Mispredict flag without valid is ignored, then the statistic saturates.
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle("stray_mispredict");
        chk("stray_mispredict.stat", stat_mispredicts, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, i, 0, 1, 1);
            cycle("stat_seq");
            chk($sformatf("stat_sat%0d", i), stat_mispredicts, sexp[i]);
        end

        for (int i = 0; i < 3000; i++) begin
            hpick = ($urandom_range(0, 1) == 1) ? m_hist : int'($urandom_range(0, HMASK));
            drive($urandom_range(0, 1), $urandom_range(0, (1 << TAG_WIDTH) - 1),
                  $urandom_range(0, 1), $urandom_range(0, (1 << TAG_WIDTH) - 1),
                  hpick, $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
